// File: rtl/single_port_mem_req_adapter.sv
// Requester-side adapter: valid/ready request channel to a single-port SRAM
// wrapper with one-cycle read latency, plus a tagged, credit-limited read
// response FIFO on a valid/ready response channel.
module single_port_mem_req_adapter #(
    parameter int unsigned DATAW     = 32,
    parameter int unsigned SIZE      = 256,
    parameter int unsigned BYTEENW   = 4,
    parameter int unsigned ADDRW     = $clog2(SIZE),
    parameter int unsigned TAGW      = 4,
    parameter int unsigned RSP_DEPTH = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    // request channel
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [ADDRW-1:0]   req_addr_i,
    input  logic [BYTEENW-1:0] req_wren_i,
    input  logic [DATAW-1:0]   req_wdata_i,
    input  logic [TAGW-1:0]    req_tag_i,
    // response channel
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DATAW-1:0]   rsp_data_o,
    output logic [TAGW-1:0]    rsp_tag_o,
    // memory wrapper port
    output logic [ADDRW-1:0]   mem_addr_o,
    output logic [BYTEENW-1:0] mem_wren_o,
    output logic [DATAW-1:0]   mem_wdata_o,
    input  logic [DATAW-1:0]   mem_rdata_i,
    // status
    output logic               busy_o
);

    localparam int unsigned CNTW = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTRW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(RSP_DEPTH);
    localparam logic [PTRW-1:0] PTR_LAST = PTRW'(RSP_DEPTH - 1);

    typedef struct packed {
        logic [TAGW-1:0]  tag;
        logic [DATAW-1:0] data;
    } rsp_entry_t;

    // credit counter: reads issued and not yet popped
    logic [CNTW-1:0] cnt_q, cnt_d;
    // in-flight read stage (memory data arrives one cycle after issue)
    logic            if_v_q, if_v_d;
    logic [TAGW-1:0] if_tag_q, if_tag_d;
    // response FIFO bookkeeping
    logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0] fcnt_q, fcnt_d;
    logic            busy_q, busy_d;
    rsp_entry_t      fifo_q [RSP_DEPTH];

    logic       is_write_c;
    logic       fire_c;
    logic       read_fire_c;
    logic       push_c;
    logic       pop_c;
    logic       fifo_full_c;
    rsp_entry_t head_c;

    // request acceptance and memory drive; credits only gate reads
    always_comb begin
        is_write_c  = |req_wren_i;
        req_ready_o = rst_ni && (is_write_c || (cnt_q < CNT_MAX));
        fire_c      = req_valid_i && req_ready_o;
        read_fire_c = fire_c && !is_write_c;
        mem_addr_o  = req_addr_i;
        mem_wdata_o = req_wdata_i;
        mem_wren_o  = fire_c ? req_wren_i : '0;
    end

    // response head; outputs held at zero while empty or in reset
    always_comb begin
        head_c      = fifo_q[rd_ptr_q];
        push_c      = if_v_q;
        fifo_full_c = (fcnt_q == CNT_MAX);
        rsp_valid_o = rst_ni && (fcnt_q != '0);
        pop_c       = rsp_valid_o && rsp_ready_i;
        rsp_data_o  = rsp_valid_o ? head_c.data : '0;
        rsp_tag_o   = rsp_valid_o ? head_c.tag  : '0;
        busy_o      = rst_ni && busy_q;
    end

    // next-state for credits, in-flight stage and FIFO pointers
    always_comb begin
        cnt_d    = cnt_q;
        fcnt_d   = fcnt_q;
        if_v_d   = 1'b0;
        if_tag_d = if_tag_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        busy_d   = 1'b0;

        cnt_d  = cnt_q  + CNTW'(read_fire_c) - CNTW'(pop_c);
        fcnt_d = fcnt_q + CNTW'(push_c)      - CNTW'(pop_c);

        if_v_d = read_fire_c;
        if (read_fire_c) begin
            if_tag_d = req_tag_i;
        end

        if (push_c) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTRW'(1);
        end
        if (pop_c) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTRW'(1);
        end

        busy_d = (cnt_d != '0);
    end

    // state registers with synchronous reset; outstanding reads are dropped
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q    <= '0;
            fcnt_q   <= '0;
            if_v_q   <= 1'b0;
            if_tag_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            fcnt_q   <= fcnt_d;
            if_v_q   <= if_v_d;
            if_tag_q <= if_tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            busy_q   <= busy_d;
        end
    end

    // FIFO storage; contents are only observed through the valid-gated head
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            fifo_q[wr_ptr_q] <= '{tag: if_tag_q, data: mem_rdata_i};
        end
    end

    // credits make a push into a full FIFO unreachable
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(push_c && fifo_full_c));
        end
    end

endmodule
